regfile_ctx: RTL and testbench
==============================

Name: regfile_ctx

Overview:
Parametrised successor of the 16-bit/64-entry processor register file. Two registered read ports, two write ports, hardwired zero register and memory-mapped IO in/out registers. Adds a handshaked serial context engine that streams registers 0..CTX_REGS-1 out (save) or in (restore), one word per cycle, replacing the old wide parallel context bus. Sits between decode/writeback and the call-frame stack controller.

Parameters:
DATA_W, 16, register width
NREGS, 64, register count; ADDR_W = clog2(NREGS)
CTX_REGS, 15, registers 0..CTX_REGS-1 form the context; 1..NREGS
ZERO_REG, 63, index that always reads 0
IO_IN_REG, 15, index loaded from io_in every cycle
IO_OUT_REG, 16, index mirrored to io_out

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rd1_en, rd2_en  in  1  read enables
rd1_addr, rd2_addr  in  ADDR_W  read addresses
rd1_data, rd2_data  out  DATA_W  registered read data
wr1_en, wr2_en  in  1  write enables
wr1_addr, wr2_addr  in  ADDR_W  write addresses
wr1_data, wr2_data  in  DATA_W  write data
io_in  in  DATA_W  external input word
io_out  out  DATA_W  registered copy of mem[IO_OUT_REG]
save_start, restore_start  in  1  single-cycle context commands
ctx_out_valid  out  1  save stream valid
ctx_out_ready  in  1  save stream ready
ctx_out_data  out  DATA_W  save stream word
ctx_in_valid  in  1  restore stream valid
ctx_in_ready  out  1  restore stream ready
ctx_in_data  in  DATA_W  restore stream word
busy  out  1  context engine not IDLE
ctx_done  out  1  one-cycle pulse at end of save/restore
wr_conflict  out  1  one-cycle pulse: port write dropped

Behaviour:
- Reset (async, rst_n=0): all registers 0; rd1_data, rd2_data, io_out, ctx_out_data 0; all valid/ready/busy/ctx_done/wr_conflict 0; state IDLE. Reset mid-save/restore aborts without ctx_done.
- Reads: if rdN_en, rdN_data <= mem[rdN_addr] at the edge (1-cycle latency, pre-write value same cycle); else hold. ZERO_REG or addr >= NREGS reads 0.
- Writes: at edge. Both ports same address: port 2 wins. Writes to ZERO_REG, IO_IN_REG, or addr >= NREGS are ignored (no conflict flag).
- IO: mem[IO_IN_REG] <= io_in every cycle. io_out <= mem[IO_OUT_REG] (new write visible on io_out 2 edges after wr asserted).
- FSM states IDLE, SAVE, RESTORE; 5-bit-or-wider counter cnt (clog2(CTX_REGS+1)).
- IDLE: save_start -> SAVE, cnt=0. restore_start -> RESTORE, cnt=0. Both high: save wins. Commands outside IDLE ignored.
- SAVE: ctx_out_valid=1, ctx_out_data=mem[cnt] combinationally from current contents. On valid&&ready: cnt++; at cnt==CTX_REGS-1 -> IDLE, ctx_done pulse next cycle. Data stable while ready low.
- RESTORE: ctx_in_ready=1. On valid&&ready: mem[cnt] <= ctx_in_data, cnt++; last word -> IDLE, ctx_done pulse. Restore write beats same-cycle port writes to same index.
- busy=1 in SAVE/RESTORE. While busy, port writes with addr < CTX_REGS are dropped and wr_conflict pulses next cycle; other writes and all reads proceed.
- Restore targeting IO_IN_REG is overwritten by io_in the next cycle (io_in priority).

Optional Feature:
REGFILE_BYPASS_EN: defined -> a read whose address matches an enabled, accepted same-cycle write (port 2 before port 1, restore beat highest) returns the write data. Undefined -> read returns pre-write contents.

Decomposition:
- Package regfile_pkg: ctx_state_e enum (IDLE, SAVE, RESTORE), default parameter constants, helper function for address-range check.
- Sub-module ctx_stream_ctrl: FSM, counter, valid/ready, ctx_done; exports cnt, save/restore write strobe. Storage, ports, IO in regfile_ctx.

Test Plan:
- Write wr1 addr 5=0x1234, read rd1 addr 5 next cycle -> rd1_data=0x1234 one cycle later; write addr 63=0xFFFF, read 63 -> 0.
- Same-cycle wr1 addr 7=0xAAAA, wr2 addr 7=0x5555 -> later read 0x5555; without REGFILE_BYPASS_EN, same-cycle read of 7 returns old value 0.
- io_in=0xBEEF -> read addr 15 gives 0xBEEF; write addr 16=0x00C3 -> io_out=0x00C3 two edges later.
- Preload regs 0..14 with i+0x100, save_start, ready toggling 1/0 -> 15 beats 0x100..0x10E in order, data held while ready=0, ctx_done single pulse, busy low after.
- restore_start with 15 words 0x200+i, valid gaps; port write addr 3 mid-restore -> dropped, wr_conflict pulse, reg 3=0x203; write addr 40 proceeds.
- rst_n low during beat 6 of save -> all outputs 0, state IDLE, no ctx_done, regs read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the context-switching register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_NREGS      = 64;
  localparam int unsigned DEF_CTX_REGS   = 15;
  localparam int unsigned DEF_ZERO_REG   = 63;
  localparam int unsigned DEF_IO_IN_REG  = 15;
  localparam int unsigned DEF_IO_OUT_REG = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } ctx_state_e;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned limit);
    return addr < limit;
  endfunction

  // Context counter needs to reach CTX_REGS; never narrower than 5 bits.
  function automatic int unsigned cnt_width(input int unsigned ctx_regs);
    int unsigned w;
    w = $clog2(ctx_regs + 1);
    return (w < 5) ? 5 : w;
  endfunction

endpackage

// File: rtl/regfile_ctx_ctrl.sv
// Serial context save/restore engine: walks registers 0..CTX_REGS-1 one beat per handshake.
module ctx_stream_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned CTX_REGS = DEF_CTX_REGS,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             save_start,
  input  logic             restore_start,
  input  logic             ctx_out_ready,
  input  logic             ctx_in_valid,
  output logic             ctx_out_valid,
  output logic             ctx_in_ready,
  output logic             busy,
  output logic             ctx_done,
  output logic             restore_we_c,
  output logic [CNT_W-1:0] cnt
);

  ctx_state_e       state;
  ctx_state_e       state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             fire_c;
  logic             last_c;
  logic             valid_nxt;
  logic             ready_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  assign fire_c = ((state == SAVE) && ctx_out_valid && ctx_out_ready) ||
                  ((state == RESTORE) && ctx_in_ready && ctx_in_valid);
  assign last_c = (cnt == CNT_W'(CTX_REGS - 1));

  // State register; handshake/status outputs are flops fed from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ctx_out_valid <= 1'b0;
      ctx_in_ready  <= 1'b0;
      busy          <= 1'b0;
      ctx_done      <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      ctx_out_valid <= valid_nxt;
      ctx_in_ready  <= ready_nxt;
      busy          <= busy_nxt;
      ctx_done      <= done_nxt;
    end
  end

  // Next state and counter; save wins over restore when both are requested.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (save_start)         state_nxt = SAVE;
        else if (restore_start) state_nxt = RESTORE;
      end
      SAVE, RESTORE: begin
        if (fire_c) begin
          if (last_c) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_nxt    = 1'b0;
    ready_nxt    = 1'b0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    restore_we_c = 1'b0;
    valid_nxt    = (state_nxt == SAVE);
    ready_nxt    = (state_nxt == RESTORE);
    busy_nxt     = (state_nxt != IDLE);
    done_nxt     = fire_c && last_c;
    restore_we_c = (state == RESTORE) && ctx_in_ready && ctx_in_valid;
  end

endmodule

// File: rtl/regfile_ctx.sv
// Two-read/two-write register file with zero reg, IO regs and serial context save/restore.
// Define REGFILE_BYPASS_EN to forward same-cycle accepted writes to the read ports.
module regfile_ctx
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W     = DEF_DATA_W,
  parameter  int unsigned NREGS      = DEF_NREGS,
  parameter  int unsigned CTX_REGS   = DEF_CTX_REGS,
  parameter  int unsigned ZERO_REG   = DEF_ZERO_REG,
  parameter  int unsigned IO_IN_REG  = DEF_IO_IN_REG,
  parameter  int unsigned IO_OUT_REG = DEF_IO_OUT_REG,
  localparam int unsigned ADDR_W     = $clog2(NREGS),
  localparam int unsigned CNT_W      = cnt_width(CTX_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd1_en,
  input  logic              rd2_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  input  logic              wr1_en,
  input  logic              wr2_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [ADDR_W-1:0] wr2_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic [DATA_W-1:0] wr2_data,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out,
  input  logic              save_start,
  input  logic              restore_start,
  output logic              ctx_out_valid,
  input  logic              ctx_out_ready,
  output logic [DATA_W-1:0] ctx_out_data,
  input  logic              ctx_in_valid,
  output logic              ctx_in_ready,
  input  logic [DATA_W-1:0] ctx_in_data,
  output logic              busy,
  output logic              ctx_done,
  output logic              wr_conflict
);

  logic [DATA_W-1:0] mem [NREGS];
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] ctx_idx;
  logic              restore_we_c;
  logic              wr1_acc_c;
  logic              wr2_acc_c;
  logic              conflict_c;
  logic [DATA_W-1:0] rd1_val_c;
  logic [DATA_W-1:0] rd2_val_c;

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return addr_in_range(32'(a), NREGS) && (32'(a) != ZERO_REG) && (32'(a) != IO_IN_REG);
  endfunction

  function automatic logic readable(input logic [ADDR_W-1:0] a);
    return addr_in_range(32'(a), NREGS) && (32'(a) != ZERO_REG);
  endfunction

  function automatic logic in_ctx(input logic [ADDR_W-1:0] a);
    return addr_in_range(32'(a), CTX_REGS);
  endfunction

  ctx_stream_ctrl #(
    .CTX_REGS (CTX_REGS),
    .CNT_W    (CNT_W)
  ) u_ctrl (
    .clk           (clk),
    .rst_n         (rst_n),
    .save_start    (save_start),
    .restore_start (restore_start),
    .ctx_out_ready (ctx_out_ready),
    .ctx_in_valid  (ctx_in_valid),
    .ctx_out_valid (ctx_out_valid),
    .ctx_in_ready  (ctx_in_ready),
    .busy          (busy),
    .ctx_done      (ctx_done),
    .restore_we_c  (restore_we_c),
    .cnt           (cnt)
  );

  assign ctx_idx      = ADDR_W'(cnt);
  assign ctx_out_data = ctx_out_valid ? mem[ctx_idx] : '0;

  // Port writes into the context window are dropped while the engine owns it.
  always_comb begin
    wr1_acc_c  = wr1_en && writable(wr1_addr) && !(busy && in_ctx(wr1_addr));
    wr2_acc_c  = wr2_en && writable(wr2_addr) && !(busy && in_ctx(wr2_addr));
    conflict_c = busy && ((wr1_en && writable(wr1_addr) && in_ctx(wr1_addr)) ||
                          (wr2_en && writable(wr2_addr) && in_ctx(wr2_addr)));
  end

  always_comb begin
    rd1_val_c = mem[rd1_addr];
    rd2_val_c = mem[rd2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr1_acc_c && (wr1_addr == rd1_addr)) rd1_val_c = wr1_data;
    if (wr2_acc_c && (wr2_addr == rd1_addr)) rd1_val_c = wr2_data;
    if (restore_we_c && (ctx_idx == rd1_addr) && (32'(ctx_idx) != IO_IN_REG)) rd1_val_c = ctx_in_data;
    if (wr1_acc_c && (wr1_addr == rd2_addr)) rd2_val_c = wr1_data;
    if (wr2_acc_c && (wr2_addr == rd2_addr)) rd2_val_c = wr2_data;
    if (restore_we_c && (ctx_idx == rd2_addr) && (32'(ctx_idx) != IO_IN_REG)) rd2_val_c = ctx_in_data;
`endif
    if (!readable(rd1_addr)) rd1_val_c = '0;
    if (!readable(rd2_addr)) rd2_val_c = '0;
  end

  // Later assignments win: port 1, port 2, restore beat, then io_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
    end else begin
      if (wr1_acc_c)    mem[wr1_addr] <= wr1_data;
      if (wr2_acc_c)    mem[wr2_addr] <= wr2_data;
      if (restore_we_c) mem[ctx_idx]  <= ctx_in_data;
      mem[IO_IN_REG] <= io_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_data    <= '0;
      rd2_data    <= '0;
      io_out      <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (rd1_en) rd1_data <= rd1_val_c;
      if (rd2_en) rd2_data <= rd2_val_c;
      io_out      <= mem[IO_OUT_REG];
      wr_conflict <= conflict_c;
    end
  end

endmodule

// File: tb/tb_regfile_ctx.sv
// Directed self-checking bench for regfile_ctx (default build or REGFILE_BYPASS_EN).
module tb_regfile_ctx;

  logic        clk;
  logic        rst_n;
  logic        rd1_en, rd2_en;
  logic [5:0]  rd1_addr, rd2_addr;
  logic [15:0] rd1_data, rd2_data;
  logic        wr1_en, wr2_en;
  logic [5:0]  wr1_addr, wr2_addr;
  logic [15:0] wr1_data, wr2_data;
  logic [15:0] io_in, io_out;
  logic        save_start, restore_start;
  logic        ctx_out_valid, ctx_out_ready;
  logic [15:0] ctx_out_data;
  logic        ctx_in_valid, ctx_in_ready;
  logic [15:0] ctx_in_data;
  logic        busy, ctx_done, wr_conflict;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_ctx dut (
    .clk(clk), .rst_n(rst_n),
    .rd1_en(rd1_en), .rd2_en(rd2_en), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .wr1_en(wr1_en), .wr2_en(wr2_en), .wr1_addr(wr1_addr), .wr2_addr(wr2_addr),
    .wr1_data(wr1_data), .wr2_data(wr2_data),
    .io_in(io_in), .io_out(io_out),
    .save_start(save_start), .restore_start(restore_start),
    .ctx_out_valid(ctx_out_valid), .ctx_out_ready(ctx_out_ready), .ctx_out_data(ctx_out_data),
    .ctx_in_valid(ctx_in_valid), .ctx_in_ready(ctx_in_ready), .ctx_in_data(ctx_in_data),
    .busy(busy), .ctx_done(ctx_done), .wr_conflict(wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rd1_en = 0; rd2_en = 0; rd1_addr = '0; rd2_addr = '0;
    wr1_en = 0; wr2_en = 0; wr1_addr = '0; wr2_addr = '0; wr1_data = '0; wr2_data = '0;
    save_start = 0; restore_start = 0; ctx_out_ready = 0; ctx_in_valid = 0; ctx_in_data = '0;
  endtask

  task automatic read1(input logic [5:0] a);
    rd1_en = 1; rd1_addr = a;
    tick;
    rd1_en = 0;
  endtask

  task automatic write1(input logic [5:0] a, input logic [15:0] d);
    wr1_en = 1; wr1_addr = a; wr1_data = d;
    tick;
    wr1_en = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; io_in = '0;
    idle_inputs();
    #12;
    n_cmp++; if ({rd1_data, rd2_data, io_out, ctx_out_data} !== 64'h0) begin
      n_bad++; $display("FAIL reset_data got=%h exp=0", {rd1_data, rd2_data, io_out, ctx_out_data}); end
    n_cmp++; if ({ctx_out_valid, ctx_in_ready, busy, ctx_done, wr_conflict} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=00000", {ctx_out_valid, ctx_in_ready, busy, ctx_done, wr_conflict}); end
    rst_n = 1;
    tick;
  endtask

  task automatic test_rw;
    write1(6'd5, 16'h1234);
    read1(6'd5);
    n_cmp++; if (rd1_data !== 16'h1234) begin n_bad++; $display("FAIL rd1_addr5 got=%h exp=1234", rd1_data); end
    rd1_addr = 6'd9;
    tick;
    n_cmp++; if (rd1_data !== 16'h1234) begin n_bad++; $display("FAIL rd1_hold got=%h exp=1234", rd1_data); end
    rd2_en = 1; rd2_addr = 6'd5;
    tick;
    rd2_en = 0;
    n_cmp++; if (rd2_data !== 16'h1234) begin n_bad++; $display("FAIL rd2_addr5 got=%h exp=1234", rd2_data); end
    write1(6'd63, 16'hFFFF);
    read1(6'd63);
    n_cmp++; if (rd1_data !== 16'h0000) begin n_bad++; $display("FAIL zero_reg got=%h exp=0000", rd1_data); end
  endtask

  task automatic test_same_addr;
    logic [15:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 16'h5555;
`else
    exp_same = 16'h0000;
`endif
    wr1_en = 1; wr1_addr = 6'd7; wr1_data = 16'hAAAA;
    wr2_en = 1; wr2_addr = 6'd7; wr2_data = 16'h5555;
    rd2_en = 1; rd2_addr = 6'd7;
    tick;
    wr1_en = 0; wr2_en = 0; rd2_en = 0;
    n_cmp++; if (rd2_data !== exp_same) begin n_bad++; $display("FAIL same_cycle_read got=%h exp=%h", rd2_data, exp_same); end
    read1(6'd7);
    n_cmp++; if (rd1_data !== 16'h5555) begin n_bad++; $display("FAIL port2_wins got=%h exp=5555", rd1_data); end
  endtask

  task automatic test_io;
    io_in = 16'hBEEF;
    tick;
    read1(6'd15);
    n_cmp++; if (rd1_data !== 16'hBEEF) begin n_bad++; $display("FAIL io_in_read got=%h exp=beef", rd1_data); end
    write1(6'd15, 16'h1111);
    read1(6'd15);
    n_cmp++; if (rd1_data !== 16'hBEEF) begin n_bad++; $display("FAIL io_in_wr_ignored got=%h exp=beef", rd1_data); end
    wr1_en = 1; wr1_addr = 6'd16; wr1_data = 16'h00C3;
    tick;
    wr1_en = 0;
    n_cmp++; if (io_out !== 16'h0000) begin n_bad++; $display("FAIL io_out_early got=%h exp=0000", io_out); end
    tick;
    n_cmp++; if (io_out !== 16'h00C3) begin n_bad++; $display("FAIL io_out got=%h exp=00c3", io_out); end
  endtask

  task automatic test_save;
    int beat, dones, cyc;
    for (int i = 0; i < 15; i++) write1(6'(i), 16'(32'h100 + i));
    save_start = 1;
    tick;
    save_start = 0;
    n_cmp++; if ({busy, ctx_out_valid} !== 2'b11) begin n_bad++; $display("FAIL save_enter got=%b exp=11", {busy, ctx_out_valid}); end
    beat = 0; dones = 0; cyc = 0;
    while (beat < 15 && cyc < 200) begin
      ctx_out_ready = (cyc % 2 == 0);
      restore_start = (cyc == 3);
      n_cmp++; if (ctx_out_valid !== 1'b1 || ctx_out_data !== 16'(32'h100 + beat)) begin
        n_bad++; $display("FAIL save_beat%0d got=%b/%h exp=1/%h", beat, ctx_out_valid, ctx_out_data, 16'(32'h100 + beat)); end
      if (ctx_out_ready) beat++;
      tick;
      if (ctx_done === 1'b1) dones++;
      cyc++;
    end
    ctx_out_ready = 0; restore_start = 0;
    n_cmp++; if (beat != 15) begin n_bad++; $display("FAIL save_timeout beats=%0d exp=15", beat); end
    repeat (3) begin tick; if (ctx_done === 1'b1) dones++; end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL save_done_pulses got=%0d exp=1", dones); end
    n_cmp++; if ({busy, ctx_out_valid, ctx_out_data} !== 18'h0) begin
      n_bad++; $display("FAIL save_exit got=%b%b/%h exp=00/0000", busy, ctx_out_valid, ctx_out_data); end
  endtask

  task automatic test_restore;
    int beat, dones, confl, cyc;
    restore_start = 1;
    tick;
    restore_start = 0;
    n_cmp++; if ({busy, ctx_in_ready} !== 2'b11) begin n_bad++; $display("FAIL restore_enter got=%b exp=11", {busy, ctx_in_ready}); end
    beat = 0; dones = 0; confl = 0; cyc = 0;
    while (beat < 15 && cyc < 200) begin
      ctx_in_valid = (cyc % 3 != 1);
      ctx_in_data  = 16'(32'h200 + beat);
      wr1_en = (cyc == 4); wr1_addr = 6'd3;  wr1_data = 16'hDEAD;
      wr2_en = (cyc == 4); wr2_addr = 6'd40; wr2_data = 16'h4040;
      n_cmp++; if (ctx_in_ready !== 1'b1) begin n_bad++; $display("FAIL restore_ready%0d got=%b exp=1", beat, ctx_in_ready); end
      if (ctx_in_valid) beat++;
      tick;
      if (wr_conflict === 1'b1) confl++;
      if (ctx_done === 1'b1) dones++;
      cyc++;
    end
    ctx_in_valid = 0; wr1_en = 0; wr2_en = 0;
    n_cmp++; if (beat != 15) begin n_bad++; $display("FAIL restore_timeout beats=%0d exp=15", beat); end
    repeat (3) begin
      tick;
      if (wr_conflict === 1'b1) confl++;
      if (ctx_done === 1'b1) dones++;
    end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL restore_done_pulses got=%0d exp=1", dones); end
    n_cmp++; if (confl != 1) begin n_bad++; $display("FAIL conflict_pulses got=%0d exp=1", confl); end
    n_cmp++; if ({busy, ctx_in_ready} !== 2'b00) begin n_bad++; $display("FAIL restore_exit got=%b exp=00", {busy, ctx_in_ready}); end
    for (int i = 0; i < 15; i++) begin
      read1(6'(i));
      n_cmp++; if (rd1_data !== 16'(32'h200 + i)) begin
        n_bad++; $display("FAIL restored_reg%0d got=%h exp=%h", i, rd1_data, 16'(32'h200 + i)); end
    end
    read1(6'd40);
    n_cmp++; if (rd1_data !== 16'h4040) begin n_bad++; $display("FAIL write_outside_ctx got=%h exp=4040", rd1_data); end
  endtask

  task automatic test_reset_mid_save;
    int dones;
    io_in = 16'h0000;
    tick;
    save_start = 1;
    tick;
    save_start = 0;
    ctx_out_ready = 1;
    repeat (6) tick;
    n_cmp++; if (ctx_out_data !== 16'h0206) begin n_bad++; $display("FAIL beat6_presented got=%h exp=0206", ctx_out_data); end
    rst_n = 0;
    #1;
    n_cmp++; if ({rd1_data, rd2_data, io_out, ctx_out_data} !== 64'h0) begin
      n_bad++; $display("FAIL midreset_data got=%h exp=0", {rd1_data, rd2_data, io_out, ctx_out_data}); end
    n_cmp++; if ({ctx_out_valid, ctx_in_ready, busy, ctx_done, wr_conflict} !== 5'b0) begin
      n_bad++; $display("FAIL midreset_flags got=%b exp=00000", {ctx_out_valid, ctx_in_ready, busy, ctx_done, wr_conflict}); end
    #2;
    rst_n = 1;
    dones = 0;
    repeat (4) begin tick; if (ctx_done === 1'b1) dones++; end
    ctx_out_ready = 0;
    n_cmp++; if (dones != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle dones=%0d busy=%b exp=0/0", dones, busy); end
    read1(6'd5);
    n_cmp++; if (rd1_data !== 16'h0000) begin n_bad++; $display("FAIL post_reset_reg5 got=%h exp=0000", rd1_data); end
    read1(6'd40);
    n_cmp++; if (rd1_data !== 16'h0000) begin n_bad++; $display("FAIL post_reset_reg40 got=%h exp=0000", rd1_data); end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_same_addr();
    test_io();
    test_save();
    test_restore();
    test_reset_mid_save();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
